// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional statistics counters are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;

  // Bits of valid at or above NREQ are zero, so wrapping the search at 16
  // yields the same index as wrapping at NREQ.
  function automatic logic [3:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr);
    logic [3:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = ptr + 4'(i);
      if (!found && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port signals seen by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][DSIZE-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       wfull;
  logic                       winc;
  logic [DSIZE-1:0]           wdata;

  modport arb (input req_valid, req_data, wfull, output req_ready, winc, wdata);
  modport src (output req_valid, req_data, wfull, input req_ready, winc, wdata);
endinterface

// File: rtl/fifo_arb_stats.sv
// Per-requester 16-bit accepted-word counters (built only with FIFO_ARB_STATS_EN).
module fifo_arb_stats #(
  parameter  int NREQ = 4,
  localparam int OW   = $clog2(NREQ)
)(
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          xfer,
  input  logic [OW-1:0] owner,
  input  logic [OW-1:0] stat_sel,
  output logic [15:0]   stat_count
);
  logic [NREQ-1:0][15:0] counters;

  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    always_ff @(posedge wclk or negedge wrst_n)
      if (!wrst_n)                         counters[i] <= '0;
      else if (xfer && owner == OW'(i))    counters[i] <= counters[i] + 16'd1;
  end

  // Non-power-of-two NREQ leaves select codes with no counter behind them.
  assign stat_count = (32'(stat_sel) < NREQ) ? counters[stat_sel] : 16'd0;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the single FIFO write port, wclk domain only.
// FIFO_ARB_STATS_EN adds stat_sel/stat_count and per-requester word counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int DSIZE    = 8,
  parameter  int NREQ     = 4,
  parameter  int MAXBURST = 4,
  localparam int OW       = $clog2(NREQ),
  localparam int CW       = $clog2(MAXBURST + 1)
)(
  input  logic          wclk,
  input  logic          wrst_n,
  fifo_wr_arbiter_if.arb bus,
  output logic [OW-1:0] owner,
  output logic          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [OW-1:0] stat_sel,
  output logic [15:0]   stat_count
`endif
);
  arb_state_e       state, state_d;
  logic [OW-1:0]    owner_d, rr_ptr, rr_d, pick, rr_next;
  logic [CW-1:0]    cnt, cnt_d;
  logic [NREQ-1:0]  ready;
  logic [DSIZE-1:0] sel_data;
  logic             xfer;

  assign pick    = OW'(rr_pick(16'(bus.req_valid), 4'(rr_ptr)));
  assign rr_next = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);

  always_comb begin
    state_d = state;
    owner_d = owner;
    rr_d    = rr_ptr;
    cnt_d   = cnt;
    ready   = '0;
    xfer    = 1'b0;
    case (state)
      IDLE: if (|bus.req_valid) begin
        owner_d = pick;
        cnt_d   = '0;
        state_d = BURST;
      end
      BURST: begin
        ready[owner] = !bus.wfull;
        xfer         = bus.req_valid[owner] & !bus.wfull;
        if (xfer) cnt_d = cnt + CW'(1);
        // A full FIFO only stalls; the grant ends on burst limit or lost valid.
        if ((xfer && cnt == CW'(MAXBURST - 1)) || !bus.req_valid[owner]) begin
          rr_d    = rr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      owner  <= owner_d;
      rr_ptr <= rr_d;
      cnt    <= cnt_d;
    end

  assign sel_data      = bus.req_data[owner];
  assign bus.wdata     = sel_data;
  assign bus.winc      = xfer;
  assign bus.req_ready = ready;
  assign busy          = (state == BURST);

`ifdef FIFO_ARB_STATS_EN
  fifo_arb_stats #(.NREQ(NREQ)) u_stats (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .xfer      (xfer),
    .owner     (owner),
    .stat_sel  (stat_sel),
    .stat_count(stat_count)
  );
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven requesters, a grant-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_fifo_wr_arbiter;
  localparam int DSIZE = 8, NREQ = 4, MAXBURST = 4;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic [1:0] owner;
  logic       busy;
`ifdef FIFO_ARB_STATS_EN
  logic [1:0]  stat_sel = '0;
  logic [15:0] stat_count;
`endif

  fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus.arb),
    .owner (owner),
    .busy  (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_count(stat_count)
`endif
  );

  always #5 wclk = ~wclk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  logic [7:0]      src_q [NREQ][$];
  logic [NREQ-1:0] hold = '0;
  int              log_own[$], log_dat[$], log_cyc[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = (src_q[i].size() > 0) && !hold[i];
      bus.req_data[i]  = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  task automatic clear_log();
    log_own.delete(); log_dat.delete(); log_cyc.delete();
  endtask

  // One clock: note which words the arbiter took, then advance those queues.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge wclk);
    acc = bus.req_ready & bus.req_valid;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic reset_dut();
    wrst_n    = 1'b0;
    bus.wfull = 1'b0;
    hold      = '0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    drive();
    repeat (2) @(posedge wclk);
    #1 wrst_n = 1'b1;
    clear_log();
  endtask

  // Reference model: grant holder, words sent in the grant, next search start.
  bit m_busy, n_busy;
  int m_owner, m_ptr, m_cnt, n_owner, n_ptr, n_cnt;

  always @(negedge wclk) begin
    logic [NREQ-1:0] er;
    logic            ew;
    if (!wrst_n) begin
      chk("rst_busy",  busy, 0);
      chk("rst_winc",  bus.winc, 0);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_owner", owner, 0);
      n_busy = 0; n_owner = 0; n_ptr = 0; n_cnt = 0;
    end else begin
      er = '0;
      ew = 1'b0;
      if (m_busy) begin
        er[m_owner] = !bus.wfull;
        ew          = bus.req_valid[m_owner] && !bus.wfull;
      end
      chk("winc",      bus.winc, ew);
      chk("req_ready", bus.req_ready, er);
      chk("busy",      busy, m_busy);
      chk("owner",     owner, m_owner);
      if (ew) chk("wdata", bus.wdata, src_q[m_owner][0]);
      if (bus.winc) begin
        log_own.push_back(owner); log_dat.push_back(bus.wdata); log_cyc.push_back(cyc);
      end
      n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++)
          if (!n_busy && bus.req_valid[(m_ptr + k) % NREQ]) begin
            n_busy = 1; n_owner = (m_ptr + k) % NREQ; n_cnt = 0;
          end
      end else if (ew) begin
        n_cnt = m_cnt + 1;
        if (n_cnt == MAXBURST) begin n_busy = 0; n_ptr = (m_owner + 1) % NREQ; end
      end else if (!bus.req_valid[m_owner]) begin
        n_busy = 0; n_ptr = (m_owner + 1) % NREQ;
      end
    end
  end

  always @(posedge wclk or negedge wrst_n)
    if (!wrst_n) begin
      m_busy <= 0; m_owner <= 0; m_ptr <= 0; m_cnt <= 0;
    end else begin
      m_busy <= n_busy; m_owner <= n_owner; m_ptr <= n_ptr; m_cnt <= n_cnt;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, r;
    bus.wfull = 1'b0;
    drive();

    // Requester 2 alone with six words: 4-word burst, IDLE gap, regrant.
    reset_dut();
    for (int j = 0; j < 6; j++) src_q[2].push_back(8'hA0 + 8'(j));
    drive();
    v = cyc;
    for (int n = 0; n < 12; n++) step();
    chk("s1_count", log_dat.size(), 6);
    if (log_dat.size() == 6) begin
      chk("s1_first_cycle", log_cyc[0], v + 1);
      for (int j = 0; j < 6; j++) begin
        chk("s1_data",  log_dat[j], 8'hA0 + j);
        chk("s1_owner", log_own[j], 2);
        chk("s1_offset", log_cyc[j] - log_cyc[0], (j < 4) ? j : j + 1);
      end
    end

    // All four requesters continuously valid.
    reset_dut();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 8; j++) src_q[i].push_back(8'(i * 16 + j));
    drive();
    for (int n = 0; n < 60 && log_dat.size() < 32; n++) step();
    chk("s2_count", log_dat.size(), 32);
    if (log_dat.size() == 32) begin
      for (int j = 0; j < 17; j++) chk("s2_order", log_own[j], (j / 4) % 4);
      chk("s2_span", log_cyc[16] - log_cyc[0], 20);
    end
`ifdef FIFO_ARB_STATS_EN
    for (int s = 0; s < NREQ; s++) begin
      stat_sel = 2'(s);
      #1 chk("s2_stat", stat_count, 8);
    end
`endif

    // Back-pressure after requester 1's second word.
    reset_dut();
    for (int j = 0; j < 4; j++) src_q[1].push_back(8'hB0 + 8'(j));
    drive();
    for (int n = 0; n < 20 && log_dat.size() < 2; n++) step();
    bus.wfull = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("s3_full_winc",  bus.winc, 0);
      chk("s3_full_ready", bus.req_ready, 0);
      chk("s3_full_busy",  busy, 1);
      step();
    end
    bus.wfull = 1'b0;
    #1 chk("s3_resume_winc", bus.winc, 1);
    chk("s3_resume_data", bus.wdata, 8'hB2);
    step();
    #1 chk("s3_last_data", bus.wdata, 8'hB3);
    step();
    #1 chk("s3_released", busy, 0);
    chk("s3_count", log_dat.size(), 4);
    if (log_cyc.size() >= 3) chk("s3_stall_gap", log_cyc[2] - log_cyc[1], 4);

    // Requester 0 drops valid after one word; next grant skips to 2.
    reset_dut();
    src_q[0].push_back(8'hC0);
    for (int j = 0; j < 2; j++) begin src_q[2].push_back(8'hD0 + 8'(j)); src_q[3].push_back(8'hE0 + 8'(j)); end
    drive();
    for (int n = 0; n < 10; n++) step();
    chk("s4_count", log_dat.size(), 5);
    if (log_dat.size() >= 2) begin
      chk("s4_first_owner", log_own[0], 0);
      chk("s4_next_owner",  log_own[1], 2);
      chk("s4_gap", log_cyc[1] - log_cyc[0], 3);
    end

    // Asynchronous reset in the middle of requester 2's burst.
    reset_dut();
    src_q[0].push_back(8'h11);
    for (int j = 0; j < 4; j++) src_q[2].push_back(8'h20 + 8'(j));
    drive();
    for (int n = 0; n < 20 && log_dat.size() < 3; n++) step();
    #2 wrst_n = 1'b0;
    #1;
    chk("s5_busy",  busy, 0);
    chk("s5_winc",  bus.winc, 0);
    chk("s5_ready", bus.req_ready, 0);
    chk("s5_owner", owner, 0);
    src_q[0].push_back(8'h12);
    drive();
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    clear_log();
    for (int n = 0; n < 6 && log_dat.size() < 1; n++) step();
    chk("s5_regrant_seen", log_dat.size(), 1);
    if (log_dat.size() >= 1) begin
      chk("s5_regrant_owner", log_own[0], 0);
      chk("s5_regrant_data",  log_dat[0], 8'h12);
    end

    // Random traffic, back-pressure and valid drops against the model.
    reset_dut();
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, NREQ - 1);
      if ($urandom_range(0, 2) != 0 && src_q[r].size() < 6) src_q[r].push_back(8'($urandom));
      bus.wfull = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NREQ; i++) hold[i] = ($urandom_range(0, 9) == 0);
      drive();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter that shares the single write port of the dual-clock FIFO between `NREQ` requesters in the write clock domain. Selects one requester round-robin, holds the grant for a bounded burst, and drives the FIFO's `winc`/`wdata` while honouring `wfull` back-pressure. Sits directly in front of the FIFO write port, with all logic in the `wclk` domain; the read side is untouched.

## Interface
- `DSIZE`, 8, data word width; must match the FIFO's `DSIZE`
- `NREQ`, 4, number of requesters (2..16)
- `MAXBURST`, 4, maximum words accepted per grant (1..255)
- `wclk`  in  1  write-domain clock; all state on the rising edge
- `wrst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NREQ  requester i has a word on its data slice
- `req_data`  in  NREQ*DSIZE  requester i data at bits [i*DSIZE +: DSIZE]
- `req_ready`  out  NREQ  word on slice i accepted this cycle (one-hot or zero)
- `wfull`  in  1  FIFO full flag, already in the `wclk` domain
- `winc`  out  1  FIFO write enable
- `wdata`  out  DSIZE  FIFO write data
- `owner`  out  $clog2(NREQ)  index of the current grant holder
- `busy`  out  1  grant held (state BURST)
- `stat_sel`  in  $clog2(NREQ)  statistics select (only with `FIFO_ARB_STATS_EN`)
- `stat_count`  out  16  accepted-word count for requester `stat_sel` (only with `FIFO_ARB_STATS_EN`)

## Operation
- FSM states: IDLE, BURST. Registers: `state`, `owner`, `rr_ptr`, `cnt` (width $clog2(MAXBURST+1)).
- IDLE: no transfers; `req_ready`=0, `winc`=0. If any `req_valid` is set, choose the first set bit searching circularly from `rr_ptr` upward; load `owner`, clear `cnt`, go to BURST. Otherwise stay.
- BURST: `req_ready[owner]` = `!wfull`; `winc` = `req_valid[owner] & !wfull`; `wdata` = slice `owner` of `req_data`. A transfer is `winc`=1.
- On each transfer `cnt` increments.
- Release when a transfer occurs with `cnt == MAXBURST-1`, or when `req_valid[owner]` = 0 (no transfer that cycle).
- On release: `rr_ptr` <= (`owner`+1) mod `NREQ`, state <= IDLE. `owner` holds its value.
- `wfull`=1 in BURST: no transfer, `cnt` holds, grant kept. A full FIFO never forces release.
- Requester contract: data is held stable while valid and not ready. Dropping valid forfeits the grant.
- Non-owners always see `req_ready`=0, and their data is ignored.
- Non-power-of-two `NREQ`: pointer arithmetic wraps at `NREQ`, never at 2^width.

## Timing
- Reset values: state IDLE, `owner`=0, `rr_ptr`=0, `cnt`=0, `busy`=0, `winc`=0, `req_ready`=0, `stat_count` counters 0. `wdata` is don't-care but driven.
- Reset asserted mid-burst: immediate return to reset values. Any partially sent burst is simply truncated.
- Arbitration latency: 1 cycle. Valid seen in IDLE at edge k gives the first possible transfer in cycle k+1.
- `winc`, `wdata` and `req_ready` are combinational from registered state plus `req_valid`/`wfull`/`req_data`. There is no registered output stage.
- Throughput: at most `MAXBURST` words per `MAXBURST`+1 cycles per grant, because of the IDLE cycle between grants.
- `busy` = (state == BURST), registered.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - One 16-bit counter per requester, incremented on each transfer for `owner`; wraps modulo 2^16.
  - `stat_count` = counter[`stat_sel`], combinational read.
  - An out-of-range `stat_sel` reads 0.
- Not defined: `stat_sel` and `stat_count` ports are absent and there are no counters. Arbitration behaviour is identical.

## Structure
- Shared package `fifo_arb_pkg`: state enum (IDLE, BURST), and function `rr_pick(valid, ptr)` returning the first set index circularly from `ptr`.
- One natural sub-module, `fifo_arb_stats`: the counter bank under `FIFO_ARB_STATS_EN`. Inputs are the transfer strobe, `owner` and `stat_sel`.
- Instantiated next to the FIFO top, with `winc`/`wdata` wired to the FIFO write port and `wfull` back from it.

## Test plan
- Reset, then requester 2 valid with data 0xA0..0xA5 and `MAXBURST`=4: IDLE 1 cycle, then 0xA0..0xA3 on consecutive cycles, release, IDLE, regrant to 2, then 0xA4, 0xA5.
- All four requesters continuously valid: grant order 0,1,2,3,0, each for 4 words with one IDLE cycle between; `rr_ptr` wraps 3 to 0.
- `wfull` asserted for 3 cycles after requester 1's second word: `winc`=0 and `req_ready`=0 for 3 cycles, `cnt` stays 2, then words 3 and 4 are written and the grant is released.
- Requester 0 drops valid after 1 word: release that cycle, and the next grant goes to the next valid index at or above 1.
- Reset pulsed mid-burst after 2 words: all outputs take reset values asynchronously, and the first grant after reset goes to the lowest valid index from 0.
- With `FIFO_ARB_STATS_EN`: after the all-valid scenario runs 32 transfers, `stat_count` reads 8 for each `stat_sel` 0..3. A counter preloaded to 0xFFFF wraps to 0 on the next transfer.
